rotate_right_seq: RTL and testbench

Sequential 32-bit rotate-right unit: the inverse of the team's combinational rotate-left block. It accepts an operand and a rotate amount over a valid/ready handshake and resolves the rotation one binary-weighted stage per clock. It holds the result until the consumer takes it. It sits beside the rotate-left block so round-trip checks (rotl then rotr by the same k) return the original word.

---
 rtl/rotate_right_seq.sv | 163 ++++++++++++++++
 tb/tb_rotate_right_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rotate_right_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_right_seq
//  Description : Sequential rotate-right unit. Accepts an operand and a rotate
//                amount over a valid/ready handshake and applies one
//                binary-weighted rotation stage per clock (stage s rotates
//                right by 2^s when bit s of the amount is set). The result is
//                held until the consumer takes it. Inverse of the
//                combinational rotate-left block.
//
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                x          - operand, sampled on acceptance
//                k          - rotate amount, only k[STAGES-1:0] used (mod WIDTH)
//                in_valid   - operand/amount valid
//                in_ready   - block can accept (IDLE only)
//                o          - rotated result (meaningful while out_valid)
//                out_valid  - result available (DONE only)
//                out_ready  - consumer takes result
//
//  Options     : ROTATE_RIGHT_SEQ_FASTZERO_EN - when defined, an accepted
//                amount of zero (mod WIDTH) skips the stage walk and goes
//                straight to DONE with o = x.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rotate_right_seq #(
    parameter int WIDTH = 32            // power of two, >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [31:0]      k,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = $clog2(WIDTH);
    // Stage counter needs at least one bit even when there is a single stage.
    localparam int S_W    = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [S_W-1:0] C_LAST_STAGE = S_W'(STAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    work_q,  work_d;
    logic [STAGES-1:0]   kreg_q,  kreg_d;
    logic [S_W-1:0]      s_q,     s_d;

    // Upper amount bits are irrelevant: rotation is modulo WIDTH.
    logic                w_unused_k;
    assign w_unused_k = ^k[31:STAGES];

    // ------------------------------------------------------------------------
    // Every candidate stage rotation of the working register; the current
    // stage selects one of them below.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]    w_stage_rot [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            assign w_stage_rot[gi] = {work_q[(2**gi)-1:0], work_q[WIDTH-1:(2**gi)]};
        end
    endgenerate

    logic [WIDTH-1:0]    w_rot;
    logic                w_take;

    always_comb begin
        w_rot  = work_q;
        w_take = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (s_q == S_W'(i)) begin
                w_rot  = w_stage_rot[i];
                w_take = kreg_q[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        kreg_d  = kreg_q;
        s_d     = s_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d = x;
                    kreg_d = k[STAGES-1:0];
                    s_d    = '0;
`ifdef ROTATE_RIGHT_SEQ_FASTZERO_EN
                    // Zero rotation needs no stages: result is x itself.
                    if (k[STAGES-1:0] == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
`else
                    state_d = ST_BUSY;
`endif
                end
            end

            ST_BUSY: begin
                // Every stage is walked regardless of the amount bit, giving
                // a fixed latency.
                if (w_take) begin
                    work_d = w_rot;
                end
                s_d = s_q + 1'b1;
                if (s_q == C_LAST_STAGE) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            kreg_q  <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            kreg_q  <= kreg_d;
            s_q     <= s_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign o         = work_q;

endmodule
`default_nettype wire

// File: tb/tb_rotate_right_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotate_right_seq
//  Description : Self-checking bench for rotate_right_seq. A reference model
//                computes the rotated word bit-by-bit from the amount modulo
//                32 and tracks the handshake timing; a compare process checks
//                the DUT against it every cycle, and directed operations
//                check hand-computed results and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_right_seq;

    localparam int WIDTH  = 32;
    localparam int STAGES = 5;
`ifdef ROTATE_RIGHT_SEQ_FASTZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] x;
    logic [31:0]      k;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] o;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    rotate_right_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .k         (k),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o         (o),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference functions: result bit i of rotr by n is x[(i+n) mod 32].
    // ------------------------------------------------------------------------
    function automatic logic [31:0] rotr_ref(input logic [31:0] v, input logic [31:0] amt);
        logic [31:0] r;
        int n;
        n = int'(amt % 32);
        for (int i = 0; i < 32; i++) r[i] = v[(i + n) % 32];
        return r;
    endfunction

    function automatic logic [31:0] rotl_ref(input logic [31:0] v, input logic [31:0] amt);
        logic [31:0] r;
        int n;
        n = int'(amt % 32);
        for (int i = 0; i < 32; i++) r[i] = v[(i - n + 32) % 32];
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: idle / waiting-for-result / holding-result, with the
    // number of edges remaining before the result appears.
    // ------------------------------------------------------------------------
    int          m_phase;       // 0 idle, 1 computing, 2 holding
    int          m_remain;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_remain <= 0;
            m_res    <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res <= rotr_ref(x, k);
                    if (FAST && (k % 32) == 0) begin
                        m_phase <= 2;
                    end else begin
                        m_phase  <= 1;
                        m_remain <= STAGES;
                    end
                end
                1: begin
                    if (m_remain == 1) m_phase <= 2;
                    m_remain <= m_remain - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (in_ready !== (m_phase == 0) || out_valid !== (m_phase == 2)) begin
                errors++;
                $display("FAIL model_handshake: in_ready=%b out_valid=%b required in_ready=%b out_valid=%b",
                         in_ready, out_valid, (m_phase == 0), (m_phase == 2));
            end
            if (m_phase == 2) begin
                checks++;
                if (o !== m_res) begin
                    errors++;
                    $display("FAIL model_result: o=%h required %h", o, m_res);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // One operation: offer, measure edges to out_valid, hold under
    // backpressure, release.
    // ------------------------------------------------------------------------
    task automatic do_op(input string name, input logic [31:0] xv, input logic [31:0] kv,
                         input logic [31:0] exp, input int exp_edges, input int hold,
                         input bit pulse);
        int edges;
        @(negedge clk);
        check({name, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        x = xv; k = kv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);                       // acceptance edge
        @(negedge clk);
        in_valid = 1'b0;
        if (pulse) begin                      // garbage offers while busy
            x = ~xv; k = kv + 32'd3; in_valid = 1'b1;
        end
        edges = 0;
        while (out_valid !== 1'b1 && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(edges), 32'(exp_edges));
        check({name, "_result"}, o, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, "_hold_o"}, o, exp);
            check({name, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);                       // release edge
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
        check({name, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rt;
        rst_n = 1'b0; x = '0; k = '0; in_valid = 1'b0; out_ready = 1'b0;
        #3;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_o", o, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        do_op("r7k2",   32'h0000_0007, 32'd2,  32'hC000_0001, 5, 0, 1'b0);
        do_op("rC7k21", 32'h0000_00C7, 32'd21, 32'h0006_3800, 5, 3, 1'b1);
        do_op("rAk35",  32'h0000_000A, 32'd35, 32'h4000_0001, 5, 1, 1'b0);
        do_op("rC00k2", 32'hC000_00C7, 32'd2,  32'hF000_0031, 5, 0, 1'b0);
        rt = rotl_ref(32'hC000_00C7, 32'd2);
        do_op("roundtrip", rt, 32'd2, 32'hC000_00C7, 5, 0, 1'b0);
        do_op("k32", 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, FAST ? 0 : 5, 2, 1'b1);
        do_op("k0",  32'h1234_5678, 32'd0,  32'h1234_5678, FAST ? 0 : 5, 0, 1'b0);
        do_op("k31", 32'h0000_0001, 32'd31, 32'h0000_0002, 5, 0, 1'b0);

        // Reset while in the middle of the stage walk.
        @(negedge clk);
        x = 32'h1234_5678; k = 32'd7; in_valid = 1'b1;
        @(posedge clk);                       // acceptance
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_o", o, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        do_op("post_rst", 32'h8000_0000, 32'd1, 32'h4000_0000, 5, 0, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
